id_control_pipe: RTL and testbench

- Registered instruction-decode control unit with a load-use hazard detector.
- Decodes opcode/funct of the IF/ID instruction into the full MIPS control bundle and loads it into the ID/EX control register.
- Inserts bubbles on load-use hazards, branch/jump flush and illegal opcodes.
- Counts stall cycles for performance monitoring.

---
 rtl/mips_ctrl_pkg.sv | 160 ++++++++++++++++
 rtl/id_control_pipe_if.sv | 54 +++++
 rtl/id_control_pipe_hazard_detect.sv | 30 +++
 rtl/id_control_pipe.sv | 92 +++++++++
 tb/tb_id_control_pipe.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared constants and types for the ID-stage control slice.
//   - opcode (instruction[31:26]) and funct (instruction[5:0]) encodings
//   - ALU operation codes
//   - ctrl_t: the registered control bundle carried into ID/EX
//   - decode_instr(): opcode/funct -> {legal, ctrl_t}
//   - uses_rs()/uses_rt(): which source registers an instruction reads
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9,
        ALU_LUI = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic    mult_a;      // ALU A: 1 = shamt, 0 = rs
        logic    mult_b;      // ALU B: 1 = extended immediate, 0 = rt
        logic    reg_dst;     // 1 = rd, 0 = rt
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    branch;
        logic    branch_ne;
        logic    jump;
        logic    link;
        logic    zero_ext;
        alu_op_e alu_op;
    } ctrl_t;

    typedef struct packed {
        logic  legal;
        ctrl_t ctrl;
    } decode_t;

    function automatic decode_t decode_instr(input logic [5:0] opcode,
                                             input logic [5:0] funct);
        decode_t d;
        d       = '0;
        d.legal = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                d.ctrl.reg_dst   = 1'b1;
                d.ctrl.reg_write = 1'b1;
                case (funct)
                    FN_ADD: d.ctrl.alu_op = ALU_ADD;
                    FN_SUB: d.ctrl.alu_op = ALU_SUB;
                    FN_AND: d.ctrl.alu_op = ALU_AND;
                    FN_OR:  d.ctrl.alu_op = ALU_OR;
                    FN_XOR: d.ctrl.alu_op = ALU_XOR;
                    FN_NOR: d.ctrl.alu_op = ALU_NOR;
                    FN_SLT: d.ctrl.alu_op = ALU_SLT;
                    FN_SLL: begin d.ctrl.alu_op = ALU_SLL; d.ctrl.mult_a = 1'b1; end
                    FN_SRL: begin d.ctrl.alu_op = ALU_SRL; d.ctrl.mult_a = 1'b1; end
                    FN_SRA: begin d.ctrl.alu_op = ALU_SRA; d.ctrl.mult_a = 1'b1; end
                    default: d = '0;
                endcase
            end
            OP_LW: begin
                d.ctrl.mult_b     = 1'b1;
                d.ctrl.mem_read   = 1'b1;
                d.ctrl.mem_to_reg = 1'b1;
                d.ctrl.reg_write  = 1'b1;
                d.ctrl.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                d.ctrl.mult_b    = 1'b1;
                d.ctrl.mem_write = 1'b1;
                d.ctrl.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                d.ctrl.branch = 1'b1;
                d.ctrl.alu_op = ALU_SUB;
            end
            OP_BNE: begin
                d.ctrl.branch    = 1'b1;
                d.ctrl.branch_ne = 1'b1;
                d.ctrl.alu_op    = ALU_SUB;
            end
            OP_ADDI: begin
                d.ctrl.mult_b    = 1'b1;
                d.ctrl.reg_write = 1'b1;
                d.ctrl.alu_op    = ALU_ADD;
            end
            OP_SLTI: begin
                d.ctrl.mult_b    = 1'b1;
                d.ctrl.reg_write = 1'b1;
                d.ctrl.alu_op    = ALU_SLT;
            end
            OP_ANDI, OP_ORI, OP_LUI: begin
                d.ctrl.mult_b    = 1'b1;
                d.ctrl.reg_write = 1'b1;
                d.ctrl.zero_ext  = 1'b1;
                d.ctrl.alu_op    = (opcode == OP_ANDI) ? ALU_AND :
                                   (opcode == OP_ORI)  ? ALU_OR  : ALU_LUI;
            end
            OP_J: begin
                d.ctrl.jump = 1'b1;
            end
            OP_JAL: begin
                d.ctrl.jump      = 1'b1;
                d.ctrl.link      = 1'b1;
                d.ctrl.reg_write = 1'b1;
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    // Shifts take their A operand from shamt, so rs is not a real source.
    function automatic logic uses_rs(input logic [5:0] opcode,
                                     input logic [5:0] funct);
        logic r;
        r = 1'b1;
        if (opcode == OP_J || opcode == OP_JAL || opcode == OP_LUI)
            r = 1'b0;
        else if (opcode == OP_RTYPE &&
                 (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA))
            r = 1'b0;
        return r;
    endfunction

    function automatic logic uses_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) ||
               (opcode == OP_BEQ)   || (opcode == OP_BNE);
    endfunction

endpackage

// File: rtl/id_control_pipe_if.sv
// id_control_pipe_if: IF/ID-side inputs and ID/EX-side outputs of the
// decode control unit.
//   master: drives the i_* instruction/hazard inputs, observes o_* outputs
//   slave : the control unit itself
interface id_control_pipe_if #(
    parameter int NB_OPCODE    = 6,
    parameter int NB_FUNCT     = 6,
    parameter int NB_REG       = 5,
    parameter int NB_ALUOP     = 4,
    parameter int NB_STALL_CNT = 16
) ();
    logic                    i_valid;
    logic [NB_OPCODE-1:0]    i_opcode;
    logic [NB_FUNCT-1:0]     i_funct;
    logic [NB_REG-1:0]       i_rs;
    logic [NB_REG-1:0]       i_rt;
    logic                    i_flush;
    logic                    i_ex_mem_read;
    logic [NB_REG-1:0]       i_ex_rt;

    logic                    o_stall;
    logic                    o_valid;
    logic                    o_signal_control_mult_A;
    logic                    o_signal_control_mult_B;
    logic                    o_reg_dst;
    logic                    o_reg_write;
    logic                    o_mem_read;
    logic                    o_mem_write;
    logic                    o_mem_to_reg;
    logic                    o_branch;
    logic                    o_branch_ne;
    logic                    o_jump;
    logic                    o_link;
    logic                    o_zero_ext;
    logic [NB_ALUOP-1:0]     o_alu_op;
    logic                    o_illegal;
    logic [NB_STALL_CNT-1:0] o_stall_cnt;

    modport master (
        output i_valid, i_opcode, i_funct, i_rs, i_rt, i_flush, i_ex_mem_read, i_ex_rt,
        input  o_stall, o_valid, o_signal_control_mult_A, o_signal_control_mult_B,
               o_reg_dst, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg,
               o_branch, o_branch_ne, o_jump, o_link, o_zero_ext, o_alu_op,
               o_illegal, o_stall_cnt
    );

    modport slave (
        input  i_valid, i_opcode, i_funct, i_rs, i_rt, i_flush, i_ex_mem_read, i_ex_rt,
        output o_stall, o_valid, o_signal_control_mult_A, o_signal_control_mult_B,
               o_reg_dst, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg,
               o_branch, o_branch_ne, o_jump, o_link, o_zero_ext, o_alu_op,
               o_illegal, o_stall_cnt
    );
endinterface

// File: rtl/id_control_pipe_hazard_detect.sv
// id_hazard_detect: combinational load-use hazard detector.
//   valid/opcode/funct/rs/rt : instruction in IF/ID
//   ex_mem_read/ex_rt        : load currently in EX and its destination
//   hazard                   : ID instruction reads the register the EX load writes
// Register 0 is never a hazard since it is hardwired to zero.
module id_hazard_detect
    import mips_ctrl_pkg::*;
#(
    parameter int NB_OPCODE = 6,
    parameter int NB_FUNCT  = 6,
    parameter int NB_REG    = 5
) (
    input  logic                 valid,
    input  logic [NB_OPCODE-1:0] opcode,
    input  logic [NB_FUNCT-1:0]  funct,
    input  logic [NB_REG-1:0]    rs,
    input  logic [NB_REG-1:0]    rt,
    input  logic                 ex_mem_read,
    input  logic [NB_REG-1:0]    ex_rt,
    output logic                 hazard
);
    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match = uses_rs(opcode, funct) && (ex_rt == rs);
        rt_match = uses_rt(opcode) && (ex_rt == rt);
        hazard   = valid && ex_mem_read && (ex_rt != '0) && (rs_match || rt_match);
    end
endmodule

// File: rtl/id_control_pipe.sv
// id_control_pipe: registered instruction-decode control unit.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus (slave)    : IF/ID instruction fields and EX load info in,
//                    combinational o_stall, registered ID/EX control bundle,
//                    o_illegal flag and saturating o_stall_cnt out.
// Flush, load-use hazard, empty slot and illegal encodings all load a bubble;
// only the illegal case additionally raises o_illegal.
module id_control_pipe
    import mips_ctrl_pkg::*;
#(
    parameter int NB_OPCODE    = 6,
    parameter int NB_FUNCT     = 6,
    parameter int NB_REG       = 5,
    parameter int NB_ALUOP     = 4,
    parameter int NB_STALL_CNT = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    id_control_pipe_if.slave bus
);
    logic                    hazard;
    logic                    stall;
    decode_t                 dec;
    ctrl_t                   ctrl_q;
    logic                    valid_q;
    logic                    illegal_q;
    logic [NB_STALL_CNT-1:0] stall_cnt_q;

    id_hazard_detect #(
        .NB_OPCODE (NB_OPCODE),
        .NB_FUNCT  (NB_FUNCT),
        .NB_REG    (NB_REG)
    ) u_hazard (
        .valid       (bus.i_valid),
        .opcode      (bus.i_opcode),
        .funct       (bus.i_funct),
        .rs          (bus.i_rs),
        .rt          (bus.i_rt),
        .ex_mem_read (bus.i_ex_mem_read),
        .ex_rt       (bus.i_ex_rt),
        .hazard      (hazard)
    );

    always_comb dec = decode_instr(bus.i_opcode, bus.i_funct);

    // A flush discards the ID instruction anyway, so holding PC would be wrong.
    assign stall = i_rst_n && hazard && !bus.i_flush;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ctrl_q      <= '0;
            valid_q     <= 1'b0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (stall && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;

            if (bus.i_flush || hazard || !bus.i_valid) begin
                ctrl_q    <= '0;
                valid_q   <= 1'b0;
                illegal_q <= 1'b0;
            end else if (!dec.legal) begin
                ctrl_q    <= '0;
                valid_q   <= 1'b0;
                illegal_q <= 1'b1;
            end else begin
                ctrl_q    <= dec.ctrl;
                valid_q   <= 1'b1;
                illegal_q <= 1'b0;
            end
        end
    end

    assign bus.o_stall                 = stall;
    assign bus.o_valid                 = valid_q;
    assign bus.o_signal_control_mult_A = ctrl_q.mult_a;
    assign bus.o_signal_control_mult_B = ctrl_q.mult_b;
    assign bus.o_reg_dst               = ctrl_q.reg_dst;
    assign bus.o_reg_write             = ctrl_q.reg_write;
    assign bus.o_mem_read              = ctrl_q.mem_read;
    assign bus.o_mem_write             = ctrl_q.mem_write;
    assign bus.o_mem_to_reg            = ctrl_q.mem_to_reg;
    assign bus.o_branch                = ctrl_q.branch;
    assign bus.o_branch_ne             = ctrl_q.branch_ne;
    assign bus.o_jump                  = ctrl_q.jump;
    assign bus.o_link                  = ctrl_q.link;
    assign bus.o_zero_ext              = ctrl_q.zero_ext;
    assign bus.o_alu_op                = NB_ALUOP'(ctrl_q.alu_op);
    assign bus.o_illegal               = illegal_q;
    assign bus.o_stall_cnt             = stall_cnt_q;
endmodule

// File: tb/tb_id_control_pipe.sv
// Self-checking bench for id_control_pipe: directed test-plan steps with
// literal expectations, then randomized traffic checked every cycle against
// a table-driven reference model. A second instance with a 2-bit stall
// counter shares the same stimulus to exercise saturation.
module tb_id_control_pipe;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       valid;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       flush;
    logic       exr;
    logic [4:0] exrt;

    id_control_pipe_if bus ();
    id_control_pipe_if #(.NB_STALL_CNT(2)) bus2 ();

    assign bus.i_valid        = valid;
    assign bus.i_opcode       = op;
    assign bus.i_funct        = fn;
    assign bus.i_rs           = rs;
    assign bus.i_rt           = rt;
    assign bus.i_flush        = flush;
    assign bus.i_ex_mem_read  = exr;
    assign bus.i_ex_rt        = exrt;
    assign bus2.i_valid       = valid;
    assign bus2.i_opcode      = op;
    assign bus2.i_funct       = fn;
    assign bus2.i_rs          = rs;
    assign bus2.i_rt          = rt;
    assign bus2.i_flush       = flush;
    assign bus2.i_ex_mem_read = exr;
    assign bus2.i_ex_rt       = exrt;

    id_control_pipe dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    id_control_pipe #(.NB_STALL_CNT(2)) dut_sat (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus2)
    );

    // Flags order: mult_A mult_B reg_dst reg_write mem_read mem_write
    //              mem_to_reg branch branch_ne jump link zero_ext
    logic [11:0] act_flags;
    assign act_flags = {bus.o_signal_control_mult_A, bus.o_signal_control_mult_B,
                        bus.o_reg_dst, bus.o_reg_write, bus.o_mem_read,
                        bus.o_mem_write, bus.o_mem_to_reg, bus.o_branch,
                        bus.o_branch_ne, bus.o_jump, bus.o_link, bus.o_zero_ext};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        bit          any_fn;
        logic [11:0] flags;
        logic [3:0]  alu;
    } entry_t;

    entry_t tbl[$];

    function automatic entry_t mk(logic [5:0] o, logic [5:0] f, bit a,
                                  logic [11:0] fl, logic [3:0] al);
        entry_t e;
        e.op = o; e.fn = f; e.any_fn = a; e.flags = fl; e.alu = al;
        return e;
    endfunction

    task automatic build_table();
        tbl.push_back(mk(6'b000000, 6'b100000, 0, 12'b0011_0000_0000, 4'd0));
        tbl.push_back(mk(6'b000000, 6'b100010, 0, 12'b0011_0000_0000, 4'd1));
        tbl.push_back(mk(6'b000000, 6'b100100, 0, 12'b0011_0000_0000, 4'd2));
        tbl.push_back(mk(6'b000000, 6'b100101, 0, 12'b0011_0000_0000, 4'd3));
        tbl.push_back(mk(6'b000000, 6'b100110, 0, 12'b0011_0000_0000, 4'd4));
        tbl.push_back(mk(6'b000000, 6'b100111, 0, 12'b0011_0000_0000, 4'd5));
        tbl.push_back(mk(6'b000000, 6'b101010, 0, 12'b0011_0000_0000, 4'd6));
        tbl.push_back(mk(6'b000000, 6'b000000, 0, 12'b1011_0000_0000, 4'd7));
        tbl.push_back(mk(6'b000000, 6'b000010, 0, 12'b1011_0000_0000, 4'd8));
        tbl.push_back(mk(6'b000000, 6'b000011, 0, 12'b1011_0000_0000, 4'd9));
        tbl.push_back(mk(6'b100011, 6'b000000, 1, 12'b0101_1010_0000, 4'd0));
        tbl.push_back(mk(6'b101011, 6'b000000, 1, 12'b0100_0100_0000, 4'd0));
        tbl.push_back(mk(6'b000100, 6'b000000, 1, 12'b0000_0001_0000, 4'd1));
        tbl.push_back(mk(6'b000101, 6'b000000, 1, 12'b0000_0001_1000, 4'd1));
        tbl.push_back(mk(6'b001000, 6'b000000, 1, 12'b0101_0000_0000, 4'd0));
        tbl.push_back(mk(6'b001010, 6'b000000, 1, 12'b0101_0000_0000, 4'd6));
        tbl.push_back(mk(6'b001100, 6'b000000, 1, 12'b0101_0000_0001, 4'd2));
        tbl.push_back(mk(6'b001101, 6'b000000, 1, 12'b0101_0000_0001, 4'd3));
        tbl.push_back(mk(6'b001111, 6'b000000, 1, 12'b0101_0000_0001, 4'd10));
        tbl.push_back(mk(6'b000010, 6'b000000, 1, 12'b0000_0000_0100, 4'd0));
        tbl.push_back(mk(6'b000011, 6'b000000, 1, 12'b0001_0000_0110, 4'd0));
    endtask

    task automatic ref_lookup(input logic [5:0] o, input logic [5:0] f, output bit legal,
                              output logic [11:0] fl, output logic [3:0] al);
        legal = 0; fl = '0; al = '0;
        foreach (tbl[i]) begin
            if (tbl[i].op == o && (tbl[i].any_fn || tbl[i].fn == f)) begin
                legal = 1; fl = tbl[i].flags; al = tbl[i].alu;
            end
        end
    endtask

    function automatic bit ref_hazard();
        bit reads_rs, reads_rt;
        reads_rs = !(op == 6'b000010 || op == 6'b000011 || op == 6'b001111) &&
                   !(op == 6'b000000 && (fn == 6'b000000 || fn == 6'b000010 || fn == 6'b000011));
        reads_rt = (op == 6'b000000 || op == 6'b101011 || op == 6'b000100 || op == 6'b000101);
        return valid && exr && exrt != 0 &&
               ((reads_rs && exrt == rs) || (reads_rt && exrt == rt));
    endfunction

    bit          m_valid = 0;
    bit          m_illegal = 0;
    logic [11:0] m_flags = '0;
    logic [3:0]  m_alu = '0;
    int          m_cnt = 0;
    int          m_cnt2 = 0;
    logic        stall_seen;

    // One clock: compare at the falling edge, advance the model, return #1
    // after the following rising edge with the new registered state visible.
    task automatic cycle();
        bit          hz, exp_stall, legal;
        logic [11:0] fl;
        logic [3:0]  al;
        @(negedge clk);
        hz        = ref_hazard();
        exp_stall = rst_n && hz && !flush;
        stall_seen = bus.o_stall;
        chk("o_valid",     32'(bus.o_valid),      32'(m_valid));
        chk("o_illegal",   32'(bus.o_illegal),    32'(m_illegal));
        chk("flags",       32'(act_flags),        32'(m_flags));
        chk("o_alu_op",    32'(bus.o_alu_op),     32'(m_alu));
        chk("o_stall",     32'(bus.o_stall),      32'(exp_stall));
        chk("o_stall_cnt", 32'(bus.o_stall_cnt),  32'(m_cnt));
        chk("sat_cnt",     32'(bus2.o_stall_cnt), 32'(m_cnt2));
        chk("sat_stall",   32'(bus2.o_stall),     32'(exp_stall));
        ref_lookup(op, fn, legal, fl, al);
        if (!rst_n) begin
            m_valid = 0; m_illegal = 0; m_flags = '0; m_alu = '0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            if (exp_stall) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            m_flags = '0; m_alu = '0; m_valid = 0; m_illegal = 0;
            if (!(flush || hz || !valid)) begin
                if (!legal) m_illegal = 1;
                else begin m_valid = 1; m_flags = fl; m_alu = al; end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] o, input logic [5:0] f,
                         input logic [4:0] s, input logic [4:0] t, input logic fl,
                         input logic er, input logic [4:0] ert);
        valid = v; op = o; fn = f; rs = s; rt = t; flush = fl; exr = er; exrt = ert;
        cycle();
    endtask

    initial begin
        build_table();
        rst_n = 0;
        drive_init();
        @(posedge clk);
        #1;

        // Reset held two cycles with LW on the inputs
        cycle();
        cycle();
        chk("rst valid",   32'(bus.o_valid), 32'd0);
        chk("rst flags",   32'(act_flags),   32'd0);
        chk("rst alu",     32'(bus.o_alu_op), 32'd0);
        chk("rst illegal", 32'(bus.o_illegal), 32'd0);
        chk("rst cnt",     32'(bus.o_stall_cnt), 32'd0);
        chk("rst stall",   32'(stall_seen), 32'd0);

        rst_n = 1;
        drive(1, 6'b000000, 6'b100000, 5'd1, 5'd2, 0, 0, 5'd0);   // ADD
        chk("add valid", 32'(bus.o_valid), 32'd1);
        chk("add flags", 32'(act_flags), 32'h300);
        chk("add alu",   32'(bus.o_alu_op), 32'd0);

        drive(1, 6'b000000, 6'b000000, 5'd0, 5'd2, 0, 0, 5'd0);   // SLL
        chk("sll flags", 32'(act_flags), 32'hB00);
        chk("sll alu",   32'(bus.o_alu_op), 32'd7);

        drive(1, 6'b100011, 6'b000000, 5'd3, 5'd4, 0, 0, 5'd0);   // LW
        chk("lw flags", 32'(act_flags), 32'h5A0);

        drive(1, 6'b000000, 6'b100000, 5'd1, 5'd2, 0, 1, 5'd2);   // load-use
        chk("lu stall", 32'(stall_seen), 32'd1);
        chk("lu valid", 32'(bus.o_valid), 32'd0);
        chk("lu flags", 32'(act_flags), 32'd0);
        chk("lu cnt",   32'(bus.o_stall_cnt), 32'd1);

        drive(1, 6'b000000, 6'b100000, 5'd1, 5'd2, 0, 1, 5'd0);   // ex_rt = 0
        chk("r0 stall", 32'(stall_seen), 32'd0);
        chk("r0 valid", 32'(bus.o_valid), 32'd1);

        drive(1, 6'b000000, 6'b100000, 5'd1, 5'd2, 1, 1, 5'd2);   // flush wins
        chk("fl stall", 32'(stall_seen), 32'd0);
        chk("fl valid", 32'(bus.o_valid), 32'd0);
        chk("fl cnt",   32'(bus.o_stall_cnt), 32'd1);

        drive(1, 6'b111111, 6'b000000, 5'd1, 5'd2, 0, 0, 5'd0);   // illegal
        chk("ill illegal", 32'(bus.o_illegal), 32'd1);
        chk("ill valid",   32'(bus.o_valid), 32'd0);

        for (int i = 0; i < 5; i++)
            drive(1, 6'b101011, 6'b000000, 5'd5, 5'd6, 0, 1, 5'd6);  // SW reads rt
        chk("sat cnt2", 32'(bus2.o_stall_cnt), 32'd3);
        chk("sat cnt",  32'(bus.o_stall_cnt), 32'd6);

        for (int i = 0; i < 1500; i++) begin
            logic [5:0] ro, rf;
            int k;
            k  = $urandom_range(0, tbl.size() - 1);
            ro = ($urandom_range(0, 9) < 8) ? tbl[k].op : 6'($urandom);
            k  = $urandom_range(0, 9);
            rf = ($urandom_range(0, 9) < 8) ? tbl[k].fn : 6'($urandom);
            rst_n = ($urandom_range(0, 49) != 0);
            drive(($urandom_range(0, 9) != 0), ro, rf,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    task automatic drive_init();
        valid = 1; op = 6'b100011; fn = '0; rs = '0; rt = '0;
        flush = 0; exr = 0; exrt = '0;
    endtask

endmodule
